// File: rtl/square_wave_gen_p.sv
// -----------------------------------------------------------------------------
// square_wave_gen_p
//
// Programmable square-wave generator. A shared prescaler divides clk into time
// units of DIV clocks. Each waveform cycle is an ON phase of on_period units
// followed by an OFF phase of off_period units. Period inputs are captured into
// shadow registers only when a cycle starts, so mid-cycle register writes never
// produce a runt pulse. Continuous mode repeats cycles back to back; burst mode
// runs burst_count cycles per start trigger and then returns to IDLE.
//
// Parameters
//   W        width of on/off period fields (time units)
//   DIV      clocks per time unit, DIV >= 1
//   BURST_W  width of the burst cycle count
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   en           global enable; low forces IDLE on the next edge
//   mode         0 = continuous, 1 = burst
//   start        burst trigger, only honoured in IDLE
//   on_period    high time in units
//   off_period   low time in units
//   burst_count  cycles per burst
//   signal       registered waveform output (high while in ON)
//   busy         registered, high whenever the generator is not IDLE
//   cycle_done   registered one-clock pulse after each completed cycle
// -----------------------------------------------------------------------------
module square_wave_gen_p #(
   parameter int W       = 4,
   parameter int DIV     = 10,
   parameter int BURST_W = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               en,
   input  logic               mode,
   input  logic               start,
   input  logic [W-1:0]       on_period,
   input  logic [W-1:0]       off_period,
   input  logic [BURST_W-1:0] burst_count,
   output logic               signal,
   output logic               busy,
   output logic               cycle_done
);

   // DIV == 1 would give a zero-width prescaler; keep one bit that never moves.
   localparam int               PRE_W   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ON   = 2'd1,
      OFF  = 2'd2
   } state_t;

   state_t               state_r;
   state_t               state_nx_s;
   state_t               start_tgt_s;

   logic [PRE_W-1:0]     pre_r;
   logic [W-1:0]         u_r;
   logic [W-1:0]         on_shadow_r;
   logic [W-1:0]         off_shadow_r;
   logic [W-1:0]         period_s;
   logic [BURST_W-1:0]   rem_r;

   logic                 phase_end_s;
   logic                 cycle_end_s;
   logic                 idle_exit_s;
   logic                 burst_load_s;
   logic                 cycle_start_s;

   logic                 signal_nx_s;
   logic                 busy_nx_s;
   logic                 cycle_done_nx_s;
   logic                 signal_r;
   logic                 busy_r;
   logic                 cycle_done_r;

   assign signal     = signal_r;
   assign busy       = busy_r;
   assign cycle_done = cycle_done_r;

   // Phase-end detection against the shadow period of the current phase.
   always_comb begin
      if (state_r == OFF) begin
         period_s = off_shadow_r;
      end else begin
         period_s = on_shadow_r;
      end
      // Phases are never entered with a zero period, so period_s - 1 cannot wrap.
      phase_end_s = (state_r != IDLE) && (pre_r == PRE_MAX) &&
                    (u_r == (period_s - W'(1)));
   end

   // Where a freshly started cycle goes, judged on the live period inputs
   // because the shadows load on that same edge.
   always_comb begin
      if (on_period != {W{1'b0}}) begin
         start_tgt_s = ON;
      end else if (off_period != {W{1'b0}}) begin
         start_tgt_s = OFF;
      end else begin
         start_tgt_s = IDLE;
      end
   end

   // Cycle boundary events; en low suppresses all of them.
   always_comb begin
      burst_load_s  = en && (state_r == IDLE) && mode && start &&
                      (burst_count != {BURST_W{1'b0}});
      idle_exit_s   = en && (state_r == IDLE) && (!mode || burst_load_s);
      // ON with no OFF phase ends the cycle directly (signal stays high).
      cycle_end_s   = en && phase_end_s &&
                      ((state_r == OFF) || (off_shadow_r == {W{1'b0}}));
      // In burst mode rem == 1 means this was the last cycle; rem == 0 means
      // the run was continuous and the switch to burst sends it back to IDLE.
      cycle_start_s = idle_exit_s ||
                      (cycle_end_s && (!mode || (rem_r > BURST_W'(1))));
   end

   // FSM next-state logic.
   always_comb begin
      if (!en) begin
         state_nx_s = IDLE;
      end else if (cycle_start_s) begin
         state_nx_s = start_tgt_s;
      end else if (cycle_end_s) begin
         state_nx_s = IDLE;
      end else if ((state_r == ON) && phase_end_s) begin
         state_nx_s = OFF;
      end else begin
         state_nx_s = state_r;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // FSM output decode, taken from the next state so the registered outputs
   // line up with the state register.
   always_comb begin
      signal_nx_s     = (state_nx_s == ON);
      busy_nx_s       = (state_nx_s != IDLE);
      cycle_done_nx_s = cycle_end_s;
   end

   // Output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         signal_r     <= 1'b0;
         busy_r       <= 1'b0;
         cycle_done_r <= 1'b0;
      end else begin
         signal_r     <= signal_nx_s;
         busy_r       <= busy_nx_s;
         cycle_done_r <= cycle_done_nx_s;
      end
   end

   // Prescaler and unit counter; both clear on every phase entry and in IDLE.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pre_r <= {PRE_W{1'b0}};
         u_r   <= {W{1'b0}};
      end else if ((state_r == IDLE) || phase_end_s || (state_nx_s == IDLE)) begin
         pre_r <= {PRE_W{1'b0}};
         u_r   <= {W{1'b0}};
      end else if (pre_r == PRE_MAX) begin
         pre_r <= {PRE_W{1'b0}};
         u_r   <= u_r + W'(1);
      end else begin
         pre_r <= pre_r + PRE_W'(1);
         u_r   <= u_r;
      end
   end

   // Shadow period registers, captured at each cycle start only.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         on_shadow_r  <= {W{1'b0}};
         off_shadow_r <= {W{1'b0}};
      end else if (cycle_start_s) begin
         on_shadow_r  <= on_period;
         off_shadow_r <= off_period;
      end else begin
         on_shadow_r  <= on_shadow_r;
         off_shadow_r <= off_shadow_r;
      end
   end

   // Remaining burst cycles; zero whenever idle or running continuously.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rem_r <= {BURST_W{1'b0}};
      end else if (state_nx_s == IDLE) begin
         rem_r <= {BURST_W{1'b0}};
      end else if (burst_load_s) begin
         rem_r <= burst_count;
      end else if (cycle_end_s && mode) begin
         rem_r <= rem_r - BURST_W'(1);
      end else if (cycle_end_s) begin
         rem_r <= {BURST_W{1'b0}};
      end else begin
         rem_r <= rem_r;
      end
   end

endmodule
